// File: rtl/io_input_debounce.sv
// io_input_debounce
//   Conditions raw board inputs (switches, keys) for the memory-mapped input
//   register: a two-flop synchroniser per bit, one shared sample prescaler and
//   a saturating per-bit debounce counter in front of a registered output word.
//   Optional feature macro: INPUT_EDGE_LATCH_EN adds sticky debounced rising-edge
//   flags (edge_flag) with a per-bit clear input (edge_clr) for key-press capture.
module io_input_debounce #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      TICK_DIV  = 50000,
  parameter int unsigned      STABLE_N  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             io_clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] in_port,
  output logic             changed,
  output logic             tick
`ifdef INPUT_EDGE_LATCH_EN
  ,
  input  logic [WIDTH-1:0] edge_clr,
  output logic [WIDTH-1:0] edge_flag
`endif
);

  // Prescaler needs at least one bit even when TICK_DIV is 1.
  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned   CW         = $clog2(STABLE_N + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_N - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] in_port_q, in_port_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] flip;

  // Two-stage synchroniser: the only logic that ever looks at raw_in.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= RESET_VAL;
      sync_q  <= RESET_VAL;
    end else begin
      sync1_q <= raw_in;
      sync_q  <= sync1_q;
    end
  end

  // Next-state for the prescaler, the registered tick and the change pulse.
  // tick_q is registered so it is low throughout reset, even with TICK_DIV=1.
  always_comb begin
    presc_d   = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    tick_d    = (presc_d == PRESC_LAST);
    changed_d = |flip;
  end

  // Prescaler and tick strobe registers.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Per-bit debounce: count consecutive differing ticks, flip on the STABLE_N-th.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_d;
    logic          flip_d;

    // Counter only moves on tick cycles; any agreeing sample restarts it.
    always_comb begin
      cnt_d  = cnt_q;
      bit_d  = in_port_q[gi];
      flip_d = 1'b0;
      if (tick_q) begin
        if (sync_q[gi] == in_port_q[gi]) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          bit_d  = sync_q[gi];
          cnt_d  = '0;
          flip_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Debounce counter register; reset discards any partial count.
    always_ff @(posedge io_clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign in_port_d[gi] = bit_d;
    assign flip[gi]      = flip_d;
  end

  // Debounced output word and its one-cycle change pulse, updated together.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      in_port_q <= RESET_VAL;
      changed_q <= 1'b0;
    end else begin
      in_port_q <= in_port_d;
      changed_q <= changed_d;
    end
  end

  assign in_port = in_port_q;
  assign changed = changed_q;
  assign tick    = tick_q;

`ifdef INPUT_EDGE_LATCH_EN
  logic [WIDTH-1:0] edge_flag_q, edge_flag_d;

  // Sticky rising-edge capture; a new rise beats a simultaneous clear.
  always_comb begin
    edge_flag_d = (edge_flag_q & ~edge_clr) | (in_port_d & ~in_port_q);
  end

  // Edge flag register.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      edge_flag_q <= '0;
    end else begin
      edge_flag_q <= edge_flag_d;
    end
  end

  assign edge_flag = edge_flag_q;
`endif

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed testbench for io_input_debounce with TICK_DIV=4, STABLE_N=3, WIDTH=32.
// Define INPUT_EDGE_LATCH_EN to also exercise edge_flag / edge_clr.
module tb_io_input_debounce;

  logic        io_clk;
  logic        resetn;
  logic [31:0] raw_in;
  logic [31:0] in_port;
  logic        changed;
  logic        tick;
`ifdef INPUT_EDGE_LATCH_EN
  logic [31:0] edge_clr;
  logic [31:0] edge_flag;
`endif

  int n_checks;
  int n_pass;

  io_input_debounce #(
    .WIDTH    (32),
    .TICK_DIV (4),
    .STABLE_N (3),
    .RESET_VAL(32'h0000_0000)
  ) dut (
    .io_clk (io_clk),
    .resetn (resetn),
    .raw_in (raw_in),
    .in_port(in_port),
    .changed(changed),
    .tick   (tick)
`ifdef INPUT_EDGE_LATCH_EN
    ,
    .edge_clr (edge_clr),
    .edge_flag(edge_flag)
`endif
  );

  initial begin
    io_clk = 1'b0;
    forever #5 io_clk = ~io_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge io_clk);
    #1;
  endtask

  task automatic drive_raw(input logic [31:0] v);
    raw_in = v;
    $display("txn raw_in <= %08h at %0t", v, $time);
  endtask

  // Step to the next cycle with tick high (bounded).
  task automatic wait_tick();
    int n;
    cyc(1);
    n = 1;
    while (!tick && n < 8) begin
      cyc(1);
      n++;
    end
    check_eq("wait_tick", {31'b0, tick}, 32'd1);
  endtask

  int seen_changed;
  int pulses;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    raw_in   = 32'hFFFF_FFFF;
`ifdef INPUT_EDGE_LATCH_EN
    edge_clr = 32'h0;
`endif

    // 1. Reset with all raw pins high.
    cyc(3);
    check_eq("rst_in_port", in_port, 32'h0);
    check_eq("rst_changed", {31'b0, changed}, 32'd0);
    check_eq("rst_tick", {31'b0, tick}, 32'd0);
    resetn = 1'b1;
    drive_raw(32'h0);
    cyc(2);
    check_eq("tick_cycle3", {31'b0, tick}, 32'd0);
    cyc(1);
    check_eq("tick_cycle4", {31'b0, tick}, 32'd1);

    // 2. Clean rising step on bit 0, tick-aligned.
    wait_tick();
    drive_raw(32'h0000_0001);
    cyc(12);
    check_eq("step_before", in_port, 32'h0);
    check_eq("step_tick12", {31'b0, tick}, 32'd1);
    cyc(1);
    check_eq("step_in_port", in_port, 32'h0000_0001);
    check_eq("step_changed", {31'b0, changed}, 32'd1);
    cyc(1);
    check_eq("step_changed_off", {31'b0, changed}, 32'd0);

    // Falling step on bit 0.
    wait_tick();
    drive_raw(32'h0);
    cyc(12);
    check_eq("fall_before", in_port, 32'h0000_0001);
    cyc(1);
    check_eq("fall_in_port", in_port, 32'h0);
    check_eq("fall_changed", {31'b0, changed}, 32'd1);

    // 3. Glitch on bit 5 lasting two ticks.
    wait_tick();
    drive_raw(32'h0000_0020);
    seen_changed = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      if (changed) seen_changed++;
      if (i == 9) begin
        check_eq("glitch_cnt_mid", 32'(dut.g_bit[5].cnt_q), 32'd2);
        drive_raw(32'h0);
      end
    end
    check_eq("glitch_cnt_clear", 32'(dut.g_bit[5].cnt_q), 32'd0);
    check_eq("glitch_in_port", in_port, 32'h0);
    check_eq("glitch_changed", 32'(seen_changed), 32'd0);

    // 4. Bits 0 and 31 together, bit 8 one tick later.
    wait_tick();
    drive_raw(32'h8000_0001);
    pulses = 0;
    for (int i = 1; i <= 18; i++) begin
      cyc(1);
      if (changed) pulses++;
      if (i == 4) begin
        check_eq("multi_tick4", {31'b0, tick}, 32'd1);
        drive_raw(32'h8000_0101);
      end
      if (i == 12) check_eq("multi_before", in_port, 32'h0);
      if (i == 13) check_eq("multi_first", in_port, 32'h8000_0001);
      if (i == 16) check_eq("multi_hold", in_port, 32'h8000_0001);
      if (i == 17) check_eq("multi_second", in_port, 32'h8000_0101);
    end
    check_eq("multi_pulses", 32'(pulses), 32'd2);

    // 5. Reset in the middle of a bit 3 count.
    wait_tick();
    drive_raw(32'h8000_0109);
    cyc(9);
    check_eq("midrst_cnt_pre", 32'(dut.g_bit[3].cnt_q), 32'd2);
    resetn = 1'b0;
    #1;
    check_eq("midrst_in_port", in_port, 32'h0);
    check_eq("midrst_cnt_rst", 32'(dut.g_bit[3].cnt_q), 32'd0);
    check_eq("midrst_tick", {31'b0, tick}, 32'd0);
    cyc(1);
    resetn = 1'b1;
    cyc(4);
    check_eq("midrst_fresh_cnt", 32'(dut.g_bit[3].cnt_q), 32'd1);
    check_eq("midrst_no_early", in_port, 32'h0);
    cyc(7);
    check_eq("midrst_before", in_port, 32'h0);
    cyc(1);
    check_eq("midrst_flip", in_port, 32'h8000_0109);
    check_eq("midrst_changed", {31'b0, changed}, 32'd1);

`ifdef INPUT_EDGE_LATCH_EN
    // 6. Sticky debounced rising-edge flags.
    edge_clr = 32'hFFFF_FFFF;
    cyc(1);
    edge_clr = 32'h0;
    check_eq("edge_clear_all", edge_flag, 32'h0);
    wait_tick();
    drive_raw(32'h8000_010D);
    cyc(13);
    check_eq("edge_rise_in", in_port, 32'h8000_010D);
    check_eq("edge_rise_flag", edge_flag, 32'h0000_0004);
    cyc(7);
    check_eq("edge_hold", edge_flag, 32'h0000_0004);
    wait_tick();
    drive_raw(32'h8000_0109);
    cyc(13);
    check_eq("edge_fall_in", in_port, 32'h8000_0109);
    check_eq("edge_fall_flag", edge_flag, 32'h0000_0004);
    wait_tick();
    drive_raw(32'h8000_010D);
    cyc(12);
    edge_clr = 32'h0000_0004;
    cyc(1);
    edge_clr = 32'h0;
    check_eq("edge_set_wins_in", in_port, 32'h8000_010D);
    check_eq("edge_set_wins", edge_flag, 32'h0000_0004);
    edge_clr = 32'h0000_0004;
    cyc(1);
    edge_clr = 32'h0;
    check_eq("edge_clr_only", edge_flag, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
